// File: rtl/rsa_job_scheduler_if.sv
// Bus-side bundle of the RSA job scheduler: key configuration, two request
// ports and a shared response channel.
interface rsa_job_scheduler_if #(
  parameter int ARQ = 16
);
  logic                 cfg_we;
  logic [1:0]           cfg_addr;
  logic [2*ARQ-1:0]     cfg_wdata;
  logic                 cfg_err;
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [2*2*ARQ-1:0]   req_data;
  logic [1:0]           resp_valid;
  logic [1:0]           resp_ready;
  logic [2*ARQ-1:0]     resp_data;
  logic                 resp_err;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, req_valid, req_data, resp_ready,
    input  cfg_err, req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, req_valid, req_data, resp_ready,
    output cfg_err, req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/rsa_job_scheduler.sv
// Shares one Mod_Exp core between an encrypt port (exponent E) and a decrypt
// port (exponent D) with round-robin arbitration, operand checks and a timeout.
module rsa_job_scheduler #(
  parameter int ARQ     = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 reset_n,
  rsa_job_scheduler_if.slave   bus,
  output logic [2*ARQ-1:0]     core_base,
  output logic [2*ARQ-1:0]     core_modulo,
  output logic [2*ARQ-1:0]     core_exponent,
  output logic                 core_start,
  input  logic                 core_finish,
  input  logic [2*ARQ-1:0]     core_result
);
  localparam int W  = 2 * ARQ;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_START, S_WAIT, S_RESP
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   key_n, key_e, key_d;
  logic           last_grant;
  logic           port_q;
  logic [W-1:0]   base_q, exp_q;
  logic [W-1:0]   resp_data_q;
  logic           resp_err_q;
  logic [CW-1:0]  wait_cnt;
  logic           cfg_err_q;

  logic           take, grant, bad_operand, finish_ok, timed_out, in_core;
  logic [1:0]     ready, resp_vld;

  assign bad_operand = (key_n == '0) || (key_n == W'(1)) || (base_q >= key_n);

  always_comb begin
    state_d   = state_q;
    take      = 1'b0;
    grant     = 1'b0;
    ready     = 2'b00;
    resp_vld  = 2'b00;
    finish_ok = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|bus.req_valid) begin
          take        = 1'b1;
          grant       = (&bus.req_valid) ? ~last_grant : bus.req_valid[1];
          ready[grant] = 1'b1;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: state_d = bad_operand ? S_RESP : S_START;
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        // First WAIT cycle ignores finish: it can still be high from the last job.
        if ((wait_cnt != '0) && core_finish) begin
          finish_ok = 1'b1;
          state_d   = S_RESP;
        end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          timed_out = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        resp_vld[port_q] = 1'b1;
        if (bus.resp_ready[port_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      key_n       <= '0;
      key_e       <= '0;
      key_d       <= '0;
      last_grant  <= 1'b1;
      port_q      <= 1'b0;
      base_q      <= '0;
      exp_q       <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      wait_cnt    <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= 1'b0;
      // Keys only change while idle with no job being accepted.
      if (bus.cfg_we) begin
        if ((state_q == S_IDLE) && !take) begin
          case (bus.cfg_addr)
            2'd0:    key_n <= bus.cfg_wdata;
            2'd1:    key_e <= bus.cfg_wdata;
            2'd2:    key_d <= bus.cfg_wdata;
            default: ;
          endcase
        end else begin
          cfg_err_q <= 1'b1;
        end
      end
      if (take) begin
        port_q     <= grant;
        base_q     <= grant ? bus.req_data[2*W-1:W] : bus.req_data[W-1:0];
        exp_q      <= grant ? key_d : key_e;
        last_grant <= grant;
      end
      case (state_q)
        S_CHECK: begin
          if (bad_operand) begin
            resp_data_q <= '0;
            resp_err_q  <= 1'b1;
          end
        end
        S_START: wait_cnt <= '0;
        S_WAIT: begin
          wait_cnt <= wait_cnt + CW'(1);
          if (finish_ok) begin
            resp_data_q <= core_result;
            resp_err_q  <= 1'b0;
          end else if (timed_out) begin
            resp_data_q <= '0;
            resp_err_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_core       = (state_q == S_START) || (state_q == S_WAIT);
  assign core_start    = (state_q == S_START);
  assign core_base     = in_core ? base_q : '0;
  assign core_modulo   = in_core ? key_n  : '0;
  assign core_exponent = in_core ? exp_q  : '0;

  assign bus.req_ready  = ready;
  assign bus.resp_valid = resp_vld;
  assign bus.resp_data  = (state_q == S_RESP) ? resp_data_q : '0;
  assign bus.resp_err   = (state_q == S_RESP) ? resp_err_q  : 1'b0;
  assign bus.cfg_err    = cfg_err_q;
endmodule

// File: tb/tb_rsa_job_scheduler.sv
// Bench for rsa_job_scheduler: behavioural Mod_Exp core, table of single jobs
// and hand sequences for arbitration, timeout, backpressure and reset.
module tb_rsa_job_scheduler;
  localparam int ARQ = 16;
  localparam int W   = 2 * ARQ;
  localparam int TO  = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  rsa_job_scheduler_if #(.ARQ(ARQ)) bus ();

  logic [W-1:0] core_base, core_modulo, core_exponent, core_result;
  logic         core_start, core_finish;

  rsa_job_scheduler #(.ARQ(ARQ), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .core_base     (core_base),
    .core_modulo   (core_modulo),
    .core_exponent (core_exponent),
    .core_start    (core_start),
    .core_finish   (core_finish),
    .core_result   (core_result)
  );

  function automatic logic [W-1:0] modpow(input logic [W-1:0] b, input logic [W-1:0] e,
                                          input logic [W-1:0] m);
    logic [63:0] r, x;
    if (m == '0) return '0;
    r = 64'(1) % 64'(m);
    x = 64'(b) % 64'(m);
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * x) % 64'(m);
      x = (x * x) % 64'(m);
    end
    return r[W-1:0];
  endfunction

  // Core model: finish stays high after a job and drops one cycle after the
  // next start, so the first WAIT cycle always sees a stale finish.
  logic         start_d = 1'b0;
  logic         hang    = 1'b0;
  logic         fin     = 1'b0;
  int           cnt     = 0;
  logic [W-1:0] res = '0, mb = '0, mm = '0, me = '0;

  always @(posedge clk) begin
    start_d <= core_start;
    if (core_start) begin
      mb <= core_base;
      mm <= core_modulo;
      me <= core_exponent;
    end
    if (start_d) begin
      fin <= 1'b0;
      cnt <= 3;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1 && !hang) begin
        fin <= 1'b1;
        res <= modpow(mb, me, mm);
      end
    end
  end
  assign core_finish = fin;
  assign core_result = res;

  typedef struct {
    int           port;
    logic [W-1:0] data;
    logic         err;
  } exp_t;

  typedef struct {
    logic [W-1:0] n, e, d;
    int           port;
    logic [W-1:0] base;
    logic [W-1:0] data;
    logic         err;
  } vec_t;

  exp_t         sb[$];
  logic [W-1:0] pend_data[2];
  logic         pend_err[2];
  int           n_cmp = 0, n_fail = 0;
  int           starts = 0, since_start = -1, last_since = -1, hold = 0;
  logic         cfg_inject = 1'b0;
  logic         active, unstable;
  logic [W-1:0] snap_b, snap_m, snap_e;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [W-1:0] data);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = data;
    tick();
    bus.cfg_we = 1'b0;
    #1;
    check("cfg_err_idle", 64'(bus.cfg_err), 64'd0);
  endtask

  task automatic set_keys(input logic [W-1:0] n, input logic [W-1:0] e, input logic [W-1:0] d);
    cfg_write(2'd0, n);
    cfg_write(2'd1, e);
    cfg_write(2'd2, d);
  endtask

  task automatic post(input int p, input logic [W-1:0] base, input logic [W-1:0] data,
                      input logic err);
    pend_data[p]         = data;
    pend_err[p]          = err;
    bus.req_data[p*W +: W] = base;
    bus.req_valid[p]     = 1'b1;
  endtask

  // Runs until one response is consumed; accepted requests are pushed to the
  // scoreboard, responses are popped and compared.
  task automatic run(input int budget);
    logic [1:0]   drop, hv, want_v;
    logic [W-1:0] hd;
    logic         he, stab;
    exp_t         e;
    bit           done;
    done        = 1'b0;
    active      = 1'b0;
    unstable    = 1'b0;
    since_start = -1;
    for (int c = 0; c < budget && !done; c++) begin
      #1;
      drop = 2'b00;
      for (int p = 0; p < 2; p++) begin
        if (bus.req_valid[p] && bus.req_ready[p]) begin
          e.port = p;
          e.data = pend_data[p];
          e.err  = pend_err[p];
          sb.push_back(e);
          drop[p] = 1'b1;
        end
      end
      if (core_start) begin
        starts++;
        snap_b = core_base;
        snap_m = core_modulo;
        snap_e = core_exponent;
        active = 1'b1;
        since_start = 0;
      end else if (active && bus.resp_valid == 2'b00) begin
        if ({core_base, core_modulo, core_exponent} !== {snap_b, snap_m, snap_e}) unstable = 1'b1;
      end
      if (cfg_inject && since_start == 4) begin
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 2'd0;
        bus.cfg_wdata = W'(99);
      end
      if (cfg_inject && since_start == 5) begin
        bus.cfg_we = 1'b0;
        check("cfg_err_wait", 64'(bus.cfg_err), 64'd1);
      end
      if (bus.resp_valid != 2'b00) begin
        last_since = since_start;
        if (hold > 0) begin
          hv = bus.resp_valid;
          hd = bus.resp_data;
          he = bus.resp_err;
          stab = 1'b1;
          for (int h = 0; h < hold; h++) begin
            tick();
            #1;
            if (bus.resp_valid !== hv || bus.resp_data !== hd || bus.resp_err !== he) stab = 1'b0;
          end
          check("resp_hold_stable", 64'(stab), 64'd1);
        end
        if (sb.size() == 0) begin
          check("sb_has_entry", 64'd0, 64'd1);
        end else begin
          e = sb.pop_front();
          want_v = 2'b01 << e.port;
          check("resp_port", 64'(bus.resp_valid), 64'(want_v));
          check("resp_data", 64'(bus.resp_data), 64'(e.data));
          check("resp_err", 64'(bus.resp_err), 64'(e.err));
        end
        bus.resp_ready = bus.resp_valid;
        tick();
        bus.resp_ready = 2'b00;
        done = 1'b1;
      end else begin
        tick();
        bus.req_valid = bus.req_valid & ~drop;
        if (since_start >= 0) since_start++;
      end
    end
    if (!done) check("resp_within_budget", 64'd0, 64'd1);
    check("core_inputs_stable", 64'(unstable), 64'd0);
  endtask

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    vecs[0] = '{7,    3,    5, 0, 2,    1, 1'b0};
    vecs[1] = '{7,    3,    5, 1, 3,    5, 1'b0};
    vecs[2] = '{1927, 1349, 5, 0, 255,  modpow(255, 1349, 1927), 1'b0};
    vecs[3] = '{1927, 1349, 5, 0, 1927, 0, 1'b1};
    vecs[4] = '{0,    3,    5, 0, 0,    0, 1'b1};
    vecs[5] = '{1,    3,    5, 1, 0,    0, 1'b1};
    vecs[6] = '{7,    3,    5, 1, 6,    6, 1'b0};
    vecs[7] = '{7,    3,    5, 0, 0,    0, 1'b0};
    vecs[8] = '{7,    3,    5, 0, 6,    6, 1'b0};
    vecs[9] = '{7,    3,    5, 0, 7,    0, 1'b1};

    reset_n        = 1'b0;
    bus.cfg_we     = 1'b0;
    bus.cfg_addr   = 2'd0;
    bus.cfg_wdata  = '0;
    bus.req_valid  = 2'b00;
    bus.req_data   = '0;
    bus.resp_ready = 2'b00;
    #1;
    check("reset_outputs", 64'(|{bus.req_ready, bus.resp_valid, bus.resp_data, bus.resp_err,
          bus.cfg_err, core_start, core_base, core_modulo, core_exponent}), 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Arbitration: port 0 wins first after reset, then alternation.
    set_keys(7, 3, 5);
    post(0, 2, 1, 1'b0);
    post(1, 3, 5, 1'b0);
    #1;
    check("rr_first_grant", 64'(bus.req_ready), 64'b01);
    run(64);
    #1;
    check("rr_second_grant", 64'(bus.req_ready), 64'b10);
    run(64);
    post(0, 2, 1, 1'b0);
    run(64);
    post(0, 2, 1, 1'b0);
    post(1, 3, 5, 1'b0);
    #1;
    check("rr_port1_first", 64'(bus.req_ready), 64'b10);
    run(64);
    run(64);

    for (int i = 0; i < 10; i++) begin
      set_keys(vecs[i].n, vecs[i].e, vecs[i].d);
      s0 = starts;
      post(vecs[i].port, vecs[i].base, vecs[i].data, vecs[i].err);
      run(64);
      check("core_start_count", 64'(starts - s0), vecs[i].err ? 64'd0 : 64'd1);
      if (!vecs[i].err)
        check("core_exponent", 64'(snap_e), 64'(vecs[i].port == 1 ? vecs[i].d : vecs[i].e));
    end

    // Timeout with stale finish at WAIT entry and a dropped key write mid-job.
    set_keys(7, 3, 5);
    hang = 1'b1;
    cfg_inject = 1'b1;
    post(0, 2, 0, 1'b1);
    run(64);
    check("timeout_cycles", 64'(last_since), 64'(TO + 1));
    cfg_inject = 1'b0;
    hang = 1'b0;
    post(0, 2, 1, 1'b0);
    run(64);
    check("n_unchanged", 64'(snap_m), 64'd7);

    // Response backpressure.
    hold = 10;
    post(1, 3, 5, 1'b0);
    run(64);
    hold = 0;

    // Reset in the middle of WAIT.
    bus.req_data[W-1:0] = W'(2);
    bus.req_valid = 2'b01;
    #1;
    check("accept_before_reset", 64'(bus.req_ready), 64'b01);
    tick();
    bus.req_valid = 2'b00;
    for (int c = 0; c < 10 && !core_start; c++) tick();
    check("core_start_seen", 64'(core_start), 64'd1);
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("reset_mid_wait_outputs", 64'(|{bus.req_ready, bus.resp_valid, bus.resp_data,
          bus.resp_err, bus.cfg_err, core_start, core_base, core_modulo, core_exponent}), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    s0 = starts;
    post(0, 0, 0, 1'b1);
    post(1, 0, 0, 1'b1);
    #1;
    check("rr_after_reset", 64'(bus.req_ready), 64'b01);
    run(64);
    run(64);
    check("keys_cleared_no_start", 64'(starts - s0), 64'd0);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
